sensor_conditioner: RTL and testbench

Front end of the irrigation controller: it takes the raw soil-sensor switches and produces the clean signals consumed by the rega validation and adubo logic. Those raw inputs are `asp_raw` (aspersão request), `got_raw` (gotejamento request) and `adb_raw` (adubo request). It synchronizes and debounces each input, and generates the slow enable `tick` on which debouncing runs. It also flags an aspersão/gotejamento conflict and pulses when any conditioned output changes.

---
 rtl/sensor_conditioner_if.sv | 22 ++
 rtl/sensor_conditioner.sv | 76 +++++++
 tb/tb_sensor_conditioner.sv | 166 ++++++++++++++++
 3 files changed

// File: rtl/sensor_conditioner_if.sv
// sensor_conditioner_if: raw switch levels in, conditioned irrigation signals out.
//   master: drives asp_raw/got_raw/adb_raw, observes tick/asp/got/adb/conflict/changed
//   slave : the conditioner itself
interface sensor_conditioner_if;
    logic asp_raw;
    logic got_raw;
    logic adb_raw;
    logic tick;
    logic asp;
    logic got;
    logic adb;
    logic conflict;
    logic changed;
    modport master (
        output asp_raw, got_raw, adb_raw,
        input  tick, asp, got, adb, conflict, changed
    );
    modport slave (
        input  asp_raw, got_raw, adb_raw,
        output tick, asp, got, adb, conflict, changed
    );
endinterface

// File: rtl/sensor_conditioner.sv
// sensor_conditioner: synchronizes and debounces the aspersao/gotejamento/adubo switches.
//   clock : system clock, rising edge
//   reset : asynchronous active-low reset
//   io    : raw switch inputs; tick, debounced asp/got/adb, conflict, changed outputs
module sensor_conditioner #(
    parameter int DIV_BITS  = 5,
    parameter int DEB_TICKS = 4
) (
    input  logic                 clock,
    input  logic                 reset,
    sensor_conditioner_if.slave  io
);
    localparam int CW = $clog2(DEB_TICKS + 1);

    logic [2:0]          raw;
    logic [2:0]          sync1_q, sync1_d;
    logic [2:0]          sync2_q, sync2_d;
    logic [2:0]          x_q, x_d;
    logic [DIV_BITS-1:0] pre_q, pre_d;
    logic [CW-1:0]       cnt_q [3];
    logic [CW-1:0]       cnt_d [3];
    logic                changed_q, changed_d;
    logic                tick;

    // bit 0 = aspersao, bit 1 = gotejamento, bit 2 = adubo
    assign raw  = {io.adb_raw, io.got_raw, io.asp_raw};
    assign tick = &pre_q;

    always_comb begin
        sync1_d = raw;
        sync2_d = sync1_q;
        pre_d   = pre_q + 1'b1;
        x_d     = x_q;
        for (int i = 0; i < 3; i++) begin
            cnt_d[i] = cnt_q[i];
            // A sample matching the output breaks the run; the DEB_TICKS-th differing one flips it.
            if (tick) begin
                if (sync2_q[i] == x_q[i]) begin
                    cnt_d[i] = '0;
                end else if (cnt_q[i] + CW'(1) == CW'(DEB_TICKS)) begin
                    x_d[i]   = sync2_q[i];
                    cnt_d[i] = '0;
                end else begin
                    cnt_d[i] = cnt_q[i] + CW'(1);
                end
            end
        end
        // x only moves on tick edges, so any difference here is a flip on this edge.
        changed_d = x_d != x_q;
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            sync1_q   <= '0;
            sync2_q   <= '0;
            x_q       <= '0;
            pre_q     <= '0;
            changed_q <= 1'b0;
            for (int i = 0; i < 3; i++) cnt_q[i] <= '0;
        end else begin
            sync1_q   <= sync1_d;
            sync2_q   <= sync2_d;
            x_q       <= x_d;
            pre_q     <= pre_d;
            changed_q <= changed_d;
            for (int i = 0; i < 3; i++) cnt_q[i] <= cnt_d[i];
        end
    end

    assign io.tick     = tick;
    assign io.asp      = x_q[0];
    assign io.got      = x_q[1];
    assign io.adb      = x_q[2];
    assign io.conflict = x_q[0] & x_q[1];
    assign io.changed  = changed_q;
endmodule

// File: tb/tb_sensor_conditioner.sv
// tb_sensor_conditioner: directed table, corner sequences and random stimulus against a reference model.
module tb_sensor_conditioner;
    localparam int P = 4;

    logic       clock = 1'b0;
    logic       reset = 1'b0;
    logic [2:0] raw   = 3'b000;

    always #5 clock = ~clock;

    sensor_conditioner_if i0 ();
    sensor_conditioner_if i1 ();

    assign i0.asp_raw = raw[0];
    assign i0.got_raw = raw[1];
    assign i0.adb_raw = raw[2];
    assign i1.asp_raw = raw[0];
    assign i1.got_raw = raw[1];
    assign i1.adb_raw = raw[2];

    sensor_conditioner #(.DIV_BITS(2), .DEB_TICKS(3)) u0 (.clock(clock), .reset(reset), .io(i0));
    sensor_conditioner #(.DIV_BITS(2), .DEB_TICKS(1)) u1 (.clock(clock), .reset(reset), .io(i1));

    int checks = 0;
    int errors = 0;

    // Reference model: edges counted from reset release, raw history and the
    // level sampled on every acting edge; an output flips once its last deb
    // samples since the previous flip all disagree with it.
    int         deb [2] = '{3, 1};
    int         k;
    logic [2:0] rh   [$];
    logic [2:0] samp [$];
    logic [2:0] mo   [2];
    int         lastf [2][3];
    logic       mchg [2];

    typedef struct {
        logic [2:0] raw;
        int         n;
        logic [5:0] exp;
    } vec_t;
    vec_t tbl [11];

    function automatic logic [5:0] dut_out(int inst);
        return inst == 0 ? {i0.tick, i0.asp, i0.got, i0.adb, i0.conflict, i0.changed}
                         : {i1.tick, i1.asp, i1.got, i1.adb, i1.conflict, i1.changed};
    endfunction

    function automatic logic [5:0] model_out(int inst);
        return {(k % P) == P - 1, mo[inst][0], mo[inst][1], mo[inst][2],
                mo[inst][0] & mo[inst][1], mchg[inst]};
    endfunction

    function automatic bit flips(int inst, int ch);
        int n = samp.size();
        if (n - lastf[inst][ch] < deb[inst]) return 1'b0;
        for (int j = n - deb[inst]; j < n; j++)
            if (samp[j][ch] == mo[inst][ch]) return 1'b0;
        return 1'b1;
    endfunction

    task automatic check(input string name, input logic [5:0] act, input logic [5:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %b expected %b", name, act, exp);
        end
    endtask

    task automatic model_reset();
        k = 0;
        rh.delete();
        samp.delete();
        for (int i = 0; i < 2; i++) begin
            mo[i]   = 3'b000;
            mchg[i] = 1'b0;
            for (int c = 0; c < 3; c++) lastf[i][c] = 0;
        end
    endtask

    task automatic do_reset(input logic [2:0] r);
        raw   = r;
        reset = 1'b0;
        #1;
        check("async_reset_deb3", dut_out(0), 6'b0);
        check("async_reset_deb1", dut_out(1), 6'b0);
        @(posedge clock);
        #1;
        check("held_reset_deb3", dut_out(0), 6'b0);
        reset = 1'b1;
        model_reset();
    endtask

    task automatic cyc(input logic [2:0] r);
        raw = r;
        @(posedge clock);
        #1;
        k++;
        rh.push_back(r);
        mchg[0] = 1'b0;
        mchg[1] = 1'b0;
        if (k % P == 0) begin
            // acting edge k sees the raw level captured two edges earlier
            samp.push_back(rh[k - 3]);
            for (int i = 0; i < 2; i++)
                for (int c = 0; c < 3; c++)
                    if (flips(i, c)) begin
                        mo[i][c]    = ~mo[i][c];
                        lastf[i][c] = samp.size();
                        mchg[i]     = 1'b1;
                    end
        end
        check($sformatf("edge%0d_deb3", k), dut_out(0), model_out(0));
        check($sformatf("edge%0d_deb1", k), dut_out(1), model_out(1));
    endtask

    initial begin
        // {tick, asp, got, adb, conflict, changed} of the DEB_TICKS=3 unit after each row
        tbl[0]  = '{3'b111, 11, 6'b100000};
        tbl[1]  = '{3'b111,  1, 6'b011111};
        tbl[2]  = '{3'b111,  1, 6'b011110};
        tbl[3]  = '{3'b101, 10, 6'b111110};
        tbl[4]  = '{3'b101,  1, 6'b010101};
        tbl[5]  = '{3'b111,  6, 6'b010100};
        tbl[6]  = '{3'b101, 10, 6'b010100};
        tbl[7]  = '{3'b111,  7, 6'b110100};
        tbl[8]  = '{3'b101,  4, 6'b110100};
        tbl[9]  = '{3'b111, 12, 6'b110100};
        tbl[10] = '{3'b111,  1, 6'b011111};

        do_reset(3'b111);
        for (int v = 0; v < 11; v++) begin
            for (int n = 0; n < tbl[v].n; n++) cyc(tbl[v].raw);
            check($sformatf("row%0d", v), dut_out(0), tbl[v].exp);
        end

        // reset in the middle of an adubo run discards the partial count
        do_reset(3'b000);
        for (int n = 0; n < 3; n++) cyc(3'b100);
        check("deb1_before_first_tick", {5'b0, i1.adb}, 6'b0);
        cyc(3'b100);
        check("deb1_first_tick", {4'b0, i1.adb, i1.changed}, 6'b000011);
        for (int n = 0; n < 5; n++) cyc(3'b100);
        check("adb_two_ticks", {5'b0, i0.adb}, 6'b0);
        do_reset(3'b100);
        for (int n = 0; n < 11; n++) cyc(3'b100);
        check("adb_fresh_run_pending", {5'b0, i0.adb}, 6'b0);
        cyc(3'b100);
        check("adb_fresh_run_done", {4'b0, i0.adb, i0.changed}, 6'b000011);

        do_reset(3'b000);
        for (int t = 0; t < 3000; ) begin
            logic [2:0] r;
            int         n;
            r = 3'($urandom);
            n = $urandom_range(1, 24);
            if ($urandom_range(0, 40) == 0) do_reset(r);
            for (int j = 0; j < n; j++) cyc(r);
            t += n;
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
